// File: rtl/AESDefinitions.sv
// Shared AES datapath types plus the GF(2^8) helpers used by the MixColumns stage.
package AESDefinitions;

    localparam int unsigned STATE_W  = 128;
    localparam int unsigned COLUMN_W = 32;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned NUM_COLS = 4;

    typedef logic [STATE_W-1:0]  state_t;
    typedef logic [COLUMN_W-1:0] column_t;
    typedef logic [BYTE_W-1:0]   byte_t;

    typedef enum logic {
        MC_FORWARD = 1'b0,
        MC_INVERSE = 1'b1
    } mc_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_fsm_t;

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a constant of up to four bits (covers 01..0e).
    function automatic byte_t gf_mul(input byte_t b, input logic [3:0] k);
        byte_t acc;
        byte_t p;
        acc = '0;
        p   = b;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Coefficient j of matrix row 0; the remaining rows are rotations of it.
    function automatic logic [3:0] mc_coef(input mc_mode_t mode, input logic [1:0] j);
        logic [3:0] coef;
        coef = 4'h0;
        case (j)
            2'd0: coef = (mode == MC_INVERSE) ? 4'he : 4'h2;
            2'd1: coef = (mode == MC_INVERSE) ? 4'hb : 4'h3;
            2'd2: coef = (mode == MC_INVERSE) ? 4'hd : 4'h1;
            2'd3: coef = (mode == MC_INVERSE) ? 4'h9 : 4'h1;
            default: coef = 4'h0;
        endcase
        return coef;
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational forward/inverse MixColumns on a single 32-bit column.
module mix_column_word
    import AESDefinitions::*;
(
    input  column_t  col_in,
    input  mc_mode_t mode,
    output column_t  col_out
);

    byte_t row_acc;
    byte_t col_byte;

    // Row r = XOR over j of coef[j] * byte[(r+j) mod 4].
    always_comb begin
        col_out  = '0;
        row_acc  = '0;
        col_byte = '0;
        for (int r = 0; r < 4; r++) begin
            row_acc = '0;
            for (int j = 0; j < 4; j++) begin
                col_byte = col_in[31-8*((r+j)%4) -: 8];
                row_acc  = row_acc ^ gf_mul(col_byte, mc_coef(mode, 2'(j)));
            end
            col_out[31-8*r -: 8] = row_acc;
        end
    end

endmodule

// File: rtl/mix_columns_multicycle.sv
// Multi-cycle MixColumns / InvMixColumns between ShiftRows and AddRoundKey.
// COLS_PER_CYCLE columns are transformed in place per clock in a shared
// working register, which also drives out_state.
// Optional: define MIX_COLUMNS_BYPASS_EN to add in_bypass (final round pass-through).
module mix_columns_multicycle
    import AESDefinitions::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   in_valid,
    output logic   in_ready,
    input  state_t in_state,
    input  logic   in_inverse,
`ifdef MIX_COLUMNS_BYPASS_EN
    input  logic   in_bypass,
`endif
    output logic   out_valid,
    input  logic   out_ready,
    output state_t out_state,
    output logic   busy
);

    localparam int unsigned NUM_STEPS = NUM_COLS / COLS_PER_CYCLE;
    localparam int unsigned STEP_W    = 2;

    // Only 1, 2 or 4 columns per clock tile the state evenly.
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $fatal(1, "mix_columns_multicycle: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    mc_fsm_t             state_q, state_d;
    state_t              work_q, work_d;
    logic [STEP_W-1:0]   step_q, step_d;
    mc_mode_t            mode_q, mode_d;
    logic                out_valid_q;
    logic                busy_q;
    logic                last_step;
`ifdef MIX_COLUMNS_BYPASS_EN
    logic                bypass_q, bypass_d;
`endif

    column_t             cols      [NUM_COLS];
    logic [STEP_W-1:0]   lane_idx  [COLS_PER_CYCLE];
    column_t             lane_in   [COLS_PER_CYCLE];
    column_t             lane_out  [COLS_PER_CYCLE];
    column_t             lane_res  [COLS_PER_CYCLE];

    // Column view of the working register.
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_cols
        assign cols[c] = work_q[127-32*c -: 32];
    end

    // One transform lane per column handled this step.
    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
        assign lane_idx[k] = STEP_W'(int'(step_q) * int'(COLS_PER_CYCLE) + k);
        assign lane_in[k]  = cols[lane_idx[k]];

        mix_column_word u_mix_column_word (
            .col_in  (lane_in[k]),
            .mode    (mode_q),
            .col_out (lane_out[k])
        );

`ifdef MIX_COLUMNS_BYPASS_EN
        assign lane_res[k] = bypass_q ? lane_in[k] : lane_out[k];
`else
        assign lane_res[k] = lane_out[k];
`endif
    end

    assign last_step = (step_q == STEP_W'(NUM_STEPS - 1));

    // Next-state, handshake and in-place column update.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        step_d   = step_q;
        mode_d   = mode_q;
        in_ready = 1'b0;
`ifdef MIX_COLUMNS_BYPASS_EN
        bypass_d = bypass_q;
`endif
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            BUSY: begin
                for (int k = 0; k < int'(COLS_PER_CYCLE); k++) begin
                    work_d[127-32*int'(lane_idx[k]) -: 32] = lane_res[k];
                end
                if (last_step) begin
                    step_d  = '0;
                    state_d = DONE;
                end else begin
                    step_d  = STEP_W'(step_q + 1'b1);
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Capture a new state whenever the handshake completes.
        if (in_valid && in_ready) begin
            work_d  = in_state;
            mode_d  = in_inverse ? MC_INVERSE : MC_FORWARD;
            step_d  = '0;
            state_d = BUSY;
`ifdef MIX_COLUMNS_BYPASS_EN
            bypass_d = in_bypass;
`endif
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            work_q      <= '0;
            step_q      <= '0;
            mode_q      <= MC_FORWARD;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MIX_COLUMNS_BYPASS_EN
            bypass_q    <= 1'b0;
`endif
        end else begin
            work_q      <= work_d;
            step_q      <= step_d;
            mode_q      <= mode_d;
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d == BUSY);
`ifdef MIX_COLUMNS_BYPASS_EN
            bypass_q    <= bypass_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_state = work_q;

endmodule

// File: doc/mix_columns_multicycle.md
Name: mix_columns_multicycle

Overview:
- Sequential successor to the combinational MixColumns/MixColumnsInverse pair.
- Accepts a 128-bit AES state over a valid/ready handshake and applies forward or inverse MixColumns, COLS_PER_CYCLE columns per clock.
- Holds the result until the consumer accepts it.
- Sits between the ShiftRows and AddRoundKey stages of the iterative round datapath, trading latency for area.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock. Legal values: 1, 2, 4; any other value is a fatal elaboration error.
- NUM_STEPS, 4/COLS_PER_CYCLE, derived (localparam); busy cycles per state.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  in_state/in_inverse are valid.
- in_ready  output  1  block can accept a state this cycle.
- in_state  input  128  state_t, FIPS-197 byte order.
- in_inverse  input  1  0 = MixColumns, 1 = InvMixColumns; sampled with in_state.
- out_valid  output  1  out_state holds a completed result.
- out_ready  input  1  consumer accepts out_state.
- out_state  output  128  state_t result.
- busy  output  1  transform in progress (FSM in BUSY).

Behaviour:
- Byte layout: column c = in_state[127-32c -: 32]; row r of column c = [127-32c-8r -: 8].
- Arithmetic: GF(2^8) modulo x^8+x^4+x^3+x+1.
  - Forward matrix rows: {02,03,01,01} rotated.
  - Inverse matrix rows: {0e,0b,0d,09} rotated.
- FSM states: IDLE, BUSY, DONE. Reset → IDLE.
- Reset values: out_valid=0, out_state=0, busy=0, step counter=0, captured mode=0. in_ready=1 after reset.
- in_ready = (IDLE) or (DONE and out_ready). Combinational from state and out_ready only; never from in_valid.
- IDLE: on in_valid & in_ready, capture in_state into working register, latch in_inverse, step=0 → BUSY.
- BUSY, each cycle:
  - Columns step*COLS_PER_CYCLE .. +COLS_PER_CYCLE-1 are replaced in place.
  - step increments.
  - On step==NUM_STEPS-1 → DONE. Step counter wraps to 0.
- DONE: out_valid=1; out_state is stable and does not change while out_valid & !out_ready.
  - out_ready & !in_valid → IDLE.
  - out_ready & in_valid → capture new input, → BUSY (back-to-back, no bubble).
- Latency: handshake accepted at edge N; out_valid high after edge N+NUM_STEPS.
  - COLS_PER_CYCLE=4 gives 1-cycle latency.
  - Peak throughput: one state per NUM_STEPS+1 cycles.
- in_inverse changes while BUSY/DONE are ignored; the latched mode applies.
- in_state changes outside the handshake are ignored.
- Asynchronous reset in BUSY or DONE discards the transaction. No output is produced for it.

Optional Feature:
- Macro MIX_COLUMNS_BYPASS_EN.
- Defined:
  - Extra input port in_bypass (1 bit), sampled with in_state.
  - When latched 1, the state passes unchanged through the same FSM and latency. This serves the final AES round, which omits MixColumns.
- Undefined: port absent; behaviour as if in_bypass=0.

Decomposition:
- Shared package AESDefinitions: state_t (128), column_t (32), byte_t (8).
- New in the same package:
  - mc_mode_t enum: MC_FORWARD=0, MC_INVERSE=1.
  - Functions xtime() and gf_mul(byte_t, 4-bit const).
- Sub-module mix_column_word:
  - Combinational, one 32-bit column, inputs column + mode, output column.
  - Instantiated COLS_PER_CYCLE times via generate.
  - Column select by step through a mux.

Test Plan:
- FIPS-197 B round 1, forward, COLS_PER_CYCLE=1: in d4bf5d30e0b452aeb84111f11e2798e5 → out 046681e5e0cb199a48f8d37a2806264c; out_valid 4 cycles after accept.
- Same vector, inverse mode, COLS_PER_CYCLE=2,4: in 046681e5…264c → out d4bf5d30…98e5; latency 2 and 1 respectively.
- Column vectors, forward: db135345→8e4da1bc, f20a225c→9fdc589d, 01010101→01010101, c6c6c6c6→c6c6c6c6, 2d26314c→4d7ebdf8. Each column is placed in column 0..3 with the others zero, and each is checked independently.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_state stable, in_ready=0. Then out_ready=1 with in_valid=1 → new state accepted the same cycle, correct results for both.
- Reset asserted mid-BUSY (step 2) → out_valid=0, in_ready=1 immediately. The next transaction is correct and no stale result is emitted.
- With MIX_COLUMNS_BYPASS_EN: in_bypass=1, in 00112233…eeff → identical out after NUM_STEPS.
